// File: rtl/sym_match_counter_if.sv
// Handshake bundle between the symbol generator / player input side and the
// round controller: symbol and guess strobes in, round status and result out.
interface sym_match_counter_if #(
    parameter int CNT_W = 5
);
    logic             Start;
    logic [7:0]       TargetSymbol;
    logic             SymValid;
    logic [7:0]       Symbol;
    logic             GuessValid;
    logic [CNT_W-1:0] Guess;
    logic             Busy;
    logic [CNT_W-1:0] SymIndex;
    logic [CNT_W-1:0] MatchCount;
    logic             RoundDone;
    logic             ResultValid;
    logic             Correct;

    modport master (
        output Start, TargetSymbol, SymValid, Symbol, GuessValid, Guess,
        input  Busy, SymIndex, MatchCount, RoundDone, ResultValid, Correct
    );

    modport slave (
        input  Start, TargetSymbol, SymValid, Symbol, GuessValid, Guess,
        output Busy, SymIndex, MatchCount, RoundDone, ResultValid, Correct
    );
endinterface

// File: rtl/sym_match_counter.sv
// Round controller: latches a target, counts matching symbols over a fixed
// round length, then judges the player's guess against the true count.
module sym_match_counter #(
    parameter int ROUND_LEN = 16,
    parameter int CNT_W     = 5
) (
    input  logic                Clk,
    input  logic                Rst_n,
    sym_match_counter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, COUNT, WAIT_GUESS, RESULT} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROUND_LEN - 1);

    state_t     state;
    logic [7:0] target;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state           <= IDLE;
            target          <= 8'h00;
            bus.Busy        <= 1'b0;
            bus.SymIndex    <= '0;
            bus.MatchCount  <= '0;
            bus.RoundDone   <= 1'b0;
            bus.ResultValid <= 1'b0;
            bus.Correct     <= 1'b0;
        end else begin
            bus.RoundDone   <= 1'b0;
            bus.ResultValid <= 1'b0;
            case (state)
                IDLE, RESULT: begin
                    if (bus.Start) begin
                        target         <= bus.TargetSymbol;
                        bus.SymIndex   <= '0;
                        bus.MatchCount <= '0;
                        bus.Correct    <= 1'b0;
                        bus.Busy       <= 1'b1;
                        state          <= COUNT;
                    end
                end
                COUNT: begin
                    if (bus.SymValid) begin
                        bus.SymIndex <= bus.SymIndex + 1'b1;
                        if (bus.Symbol == target)
                            bus.MatchCount <= bus.MatchCount + 1'b1;
                        // Compare against the pre-increment index so the pulse
                        // lines up with the last symbol being consumed.
                        if (bus.SymIndex == LAST_IDX) begin
                            bus.RoundDone <= 1'b1;
                            state         <= WAIT_GUESS;
                        end
                    end
                end
                WAIT_GUESS: begin
                    if (bus.GuessValid) begin
                        bus.Correct     <= (bus.Guess == bus.MatchCount);
                        bus.ResultValid <= 1'b1;
                        bus.Busy        <= 1'b0;
                        state           <= RESULT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sym_match_counter.sv
// Scoreboard bench: a cycle model pushes expected RoundDone/ResultValid
// records as stimulus is driven; a monitor pops them when the DUT pulses.
module tb_sym_match_counter;
    localparam int CNT_W = 5;
    localparam int RL    = 16;

    typedef struct packed {
        logic [CNT_W-1:0] idx;
        logic [CNT_W-1:0] mc;
    } rd_exp_t;

    typedef struct packed {
        logic [CNT_W-1:0] mc;
        logic             cor;
    } rv_exp_t;

    logic Clk = 1'b0;
    logic Rst_n;
    always #5 Clk = ~Clk;

    sym_match_counter_if #(.CNT_W(CNT_W)) ifc  ();
    sym_match_counter_if #(.CNT_W(CNT_W)) ifc1 ();

    sym_match_counter #(.ROUND_LEN(RL), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .bus(ifc.slave)
    );
    sym_match_counter #(.ROUND_LEN(1), .CNT_W(CNT_W)) dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .bus(ifc1.slave)
    );

    int n_chk = 0;
    int n_pass = 0;

    rd_exp_t rd_q[$];
    rv_exp_t rv_q[$];

    // Reference model state for the ROUND_LEN=16 instance
    int       m_state;
    logic [7:0] m_tgt;
    int       m_idx, m_mc;
    logic     m_cor;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic chk_state();
        chk("idx",  32'(ifc.SymIndex),   32'(m_idx));
        chk("mc",   32'(ifc.MatchCount), 32'(m_mc));
        chk("busy", 32'(ifc.Busy),       32'(m_state == 1 || m_state == 2));
        chk("cor",  32'(ifc.Correct),    32'(m_cor));
    endtask

    // One clock of stimulus on the main DUT, with model update before the edge.
    task automatic cyc(input logic st, input logic [7:0] tgt, input logic sv,
                       input logic [7:0] sym, input logic gv, input logic [CNT_W-1:0] gs);
        @(negedge Clk);
        ifc.Start = st; ifc.TargetSymbol = tgt; ifc.SymValid = sv;
        ifc.Symbol = sym; ifc.GuessValid = gv; ifc.Guess = gs;
        case (m_state)
            0, 3: if (st) begin
                m_tgt = tgt; m_idx = 0; m_mc = 0; m_cor = 1'b0; m_state = 1;
            end
            1: if (sv) begin
                m_idx++;
                if (sym == m_tgt) m_mc++;
                if (m_idx == RL) begin
                    m_state = 2;
                    rd_q.push_back('{idx: CNT_W'(m_idx), mc: CNT_W'(m_mc)});
                end
            end
            2: if (gv) begin
                m_cor = (32'(gs) == 32'(m_mc));
                m_state = 3;
                rv_q.push_back('{mc: CNT_W'(m_mc), cor: m_cor});
            end
            default: ;
        endcase
        @(posedge Clk); #1;
        ifc.Start = 1'b0; ifc.SymValid = 1'b0; ifc.GuessValid = 1'b0;
        chk_state();
    endtask

    task automatic do_reset(input int n);
        @(negedge Clk);
        Rst_n = 1'b0;
        repeat (n) @(posedge Clk);
        #1;
        m_state = 0; m_idx = 0; m_mc = 0; m_cor = 1'b0; m_tgt = 8'h00;
        chk_state();
        chk("rst_rd", 32'(ifc.RoundDone),   0);
        chk("rst_rv", 32'(ifc.ResultValid), 0);
        Rst_n = 1'b1;
    endtask

    // Feed a full round; mask selects which positions carry the target.
    task automatic feed(input logic [7:0] tgt, input logic [7:0] drive_tgt,
                        input logic [15:0] mask, input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] s;
            s = mask[i] ? tgt : (i[0] ? drive_tgt : (tgt ^ 8'h40));
            cyc(1'b0, drive_tgt, 1'b1, s, 1'b0, '0);
        end
    endtask

    always @(posedge Clk) begin
        #1;
        if (Rst_n && ifc.RoundDone) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                chk("rd_idx",  32'(ifc.SymIndex),   32'(e.idx));
                chk("rd_mc",   32'(ifc.MatchCount), 32'(e.mc));
                chk("rd_busy", 32'(ifc.Busy),       1);
            end
        end
        if (Rst_n && ifc.ResultValid) begin
            if (rv_q.size() == 0) chk("rv_unexpected", 1, 0);
            else begin
                rv_exp_t e;
                e = rv_q.pop_front();
                chk("rv_cor",  32'(ifc.Correct),    32'(e.cor));
                chk("rv_mc",   32'(ifc.MatchCount), 32'(e.mc));
                chk("rv_busy", 32'(ifc.Busy),       0);
            end
        end
    end

    initial begin
        Rst_n = 1'b0;
        ifc.Start = 0; ifc.TargetSymbol = 0; ifc.SymValid = 0; ifc.Symbol = 0;
        ifc.GuessValid = 0; ifc.Guess = 0;
        ifc1.Start = 0; ifc1.TargetSymbol = 0; ifc1.SymValid = 0; ifc1.Symbol = 0;
        ifc1.GuessValid = 0; ifc1.Guess = 0;
        m_state = 0; m_idx = 0; m_mc = 0; m_cor = 0; m_tgt = 0;

        // Reset and idle strobes
        do_reset(2);
        cyc(1'b0, 8'h00, 1'b1, 8'h00, 1'b1, '0);
        cyc(1'b0, 8'h00, 1'b1, 8'h11, 1'b1, 5'd0);
        chk("idle_idx", 32'(ifc.SymIndex), 0);

        // Round 1: target EA, 3 matches, ignored Start/Guess mid-count
        cyc(1'b1, 8'hEA, 1'b1, 8'hEA, 1'b0, '0);   // same-cycle symbol not counted
        chk("start_idx", 32'(ifc.SymIndex), 0);
        for (int i = 0; i < RL; i++) begin
            logic [7:0] s;
            logic [15:0] mask;
            mask = 16'h0109;
            s = mask[i] ? 8'hEA : (8'h10 | 8'(i));
            // Start and Guess on symbol 5 are ignored; Guess on the last symbol too
            cyc(i == 5, 8'h00, 1'b1, s, (i == 5) || (i == RL-1), 5'd3);
        end
        chk("r1_idx", 32'(ifc.SymIndex), 16);
        chk("r1_mc",  32'(ifc.MatchCount), 3);
        cyc(1'b0, 8'h00, 1'b1, 8'hEA, 1'b0, '0);   // symbol in WAIT_GUESS ignored
        chk("wg_idx", 32'(ifc.SymIndex), 16);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 5'd3);
        chk("r1_cor", 32'(ifc.Correct), 1);
        cyc(1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 5'd0); // RESULT holds
        chk("r1_hold", 32'(ifc.Correct), 1);

        // Round 2: target BF, TargetSymbol driven to F8 after Start, 5 matches
        cyc(1'b1, 8'hBF, 1'b0, 8'h00, 1'b0, '0);
        chk("r2_cor_clr", 32'(ifc.Correct), 0);
        feed(8'hBF, 8'hF8, 16'h8431, RL);
        chk("r2_mc", 32'(ifc.MatchCount), 5);
        cyc(1'b0, 8'hF8, 1'b0, 8'h00, 1'b1, 5'd4);
        chk("r2_cor", 32'(ifc.Correct), 0);

        // Start from RESULT, then reset after 7 symbols
        cyc(1'b1, 8'h33, 1'b1, 8'h33, 1'b0, '0);
        feed(8'h33, 8'h33, 16'h0055, 7);
        chk("r3_idx", 32'(ifc.SymIndex), 7);
        do_reset(1);
        cyc(1'b0, 8'h00, 1'b1, 8'h33, 1'b0, '0);
        chk("post_rst_idx", 32'(ifc.SymIndex), 0);

        // Round 4: all 16 match, no wrap
        cyc(1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, '0);
        feed(8'h5A, 8'h5A, 16'hFFFF, RL);
        chk("r4_mc", 32'(ifc.MatchCount), 16);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 5'd16);
        chk("r4_cor", 32'(ifc.Correct), 1);

        // ROUND_LEN=1 instance
        @(negedge Clk); ifc1.Start = 1'b1; ifc1.TargetSymbol = 8'hC3;
        @(posedge Clk); #1; ifc1.Start = 1'b0;
        chk("rl1_busy", 32'(ifc1.Busy), 1);
        @(negedge Clk); ifc1.SymValid = 1'b1; ifc1.Symbol = 8'hC3;
        @(posedge Clk); #1; ifc1.SymValid = 1'b0;
        chk("rl1_rd",  32'(ifc1.RoundDone), 1);
        chk("rl1_idx", 32'(ifc1.SymIndex), 1);
        chk("rl1_mc",  32'(ifc1.MatchCount), 1);
        @(posedge Clk); #1;
        chk("rl1_rd_pulse", 32'(ifc1.RoundDone), 0);
        @(negedge Clk); ifc1.GuessValid = 1'b1; ifc1.Guess = 5'd1;
        @(posedge Clk); #1; ifc1.GuessValid = 1'b0;
        chk("rl1_rv",  32'(ifc1.ResultValid), 1);
        chk("rl1_cor", 32'(ifc1.Correct), 1);

        repeat (2) @(posedge Clk);
        #2;
        chk("rd_q_empty", 32'(rd_q.size()), 0);
        chk("rv_q_empty", 32'(rv_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sym_match_counter.md
# sym_match_counter

Round controller and match counter sitting directly downstream of the symbol generator. Over one round it consumes a fixed number of 8-bit symbol patterns and counts how many equal a target pattern latched at round start. It then accepts the player's guess and reports whether the guess equals the true count. It drives the round-status and result indications for the display/score logic.

## Interface
- ROUND_LEN, 16: symbols per round; legal range 1..2^CNT_W-1.
- CNT_W, 5: width of count, index and guess fields.

- Clk  in  1  system clock; all logic on rising edge.
- Rst_n  in  1  reset, synchronous, active-low.
- Start  in  1  one-cycle request to begin a round.
- TargetSymbol  in  8  pattern to count; sampled only on an accepted Start.
- SymValid  in  1  one-cycle strobe: Symbol carries a new generated pattern.
- Symbol  in  8  generated symbol pattern.
- GuessValid  in  1  one-cycle strobe: Guess is the player's answer.
- Guess  in  CNT_W  player's count guess.
- Busy  out  1  high in COUNT and WAIT_GUESS.
- SymIndex  out  CNT_W  number of symbols consumed this round.
- MatchCount  out  CNT_W  matches counted this round.
- RoundDone  out  1  one-cycle pulse when the last symbol of the round is consumed.
- ResultValid  out  1  one-cycle pulse when the guess is judged.
- Correct  out  1  Guess == MatchCount; valid from ResultValid until the next accepted Start.

## Operation
- State machine states: IDLE, COUNT, WAIT_GUESS, RESULT.
- IDLE: Start=1 latches TargetSymbol, clears SymIndex, MatchCount and Correct, and moves to COUNT. SymValid and GuessValid are ignored.
- COUNT: each SymValid increments SymIndex. If Symbol == latched target (exact 8-bit compare), MatchCount also increments.
  - When SymValid brings SymIndex to ROUND_LEN, the state moves to WAIT_GUESS and RoundDone pulses.
  - Start and GuessValid are ignored.
- WAIT_GUESS: GuessValid registers Correct <= (Guess == MatchCount), pulses ResultValid, and moves to RESULT. SymValid and Start are ignored.
- RESULT: SymIndex, MatchCount and Correct hold. Start behaves exactly as in IDLE and begins a new round. SymValid and GuessValid are ignored.
- Arithmetic: counters are unsigned CNT_W bits.
  - MatchCount ≤ SymIndex ≤ ROUND_LEN, so counters never wrap.
  - Guess compare is full CNT_W width with no truncation.
- The target is latched, so a TargetSymbol change mid-round has no effect.

## Timing
- Reset (Rst_n=0 at a rising edge): next state IDLE. Busy, SymIndex, MatchCount, RoundDone, ResultValid and Correct are all 0. The latched target is 8'h00.
- Reset mid-round (any state) aborts the round with no RoundDone or ResultValid pulse. Reset has priority over all inputs in the same cycle.
- Start accepted at edge N: Busy=1 and counters=0 after edge N. A SymValid in the same cycle as Start is not counted.
- SymValid at edge N: updated SymIndex and MatchCount are visible after edge N (1-cycle latency).
- Last symbol at edge N: after edge N, RoundDone=1 for exactly one cycle, Busy stays 1 and state is WAIT_GUESS.
  - A GuessValid in that same cycle is ignored.
  - The earliest accepted GuessValid is at edge N+1.
- GuessValid at edge M: after edge M, ResultValid=1 for one cycle, Correct is valid, and Busy=0.
- Back-to-back SymValid every cycle is supported; there is no minimum spacing.

## Test plan
- Reset/idle:
  - Hold Rst_n=0 for 2 cycles, then pulse SymValid and GuessValid in IDLE -> all outputs remain 0 and Busy=0.
- Full round, correct guess:
  - ROUND_LEN=16, target 8'b11101010. Feed 16 symbols, 3 equal to the target, with SymValid every cycle.
  - -> RoundDone pulses after the 16th symbol; SymIndex=16, MatchCount=3.
  - Guess=3 -> ResultValid pulse, Correct=1, Busy=0.
- Wrong guess, target changed mid-round:
  - Target 8'b10111111, with TargetSymbol changed to 8'b11111000 after Start. Feed 16 symbols, 5 matching the original target.
  - -> MatchCount=5; Guess=4 -> Correct=0.
- Ignored events:
  - Start and GuessValid during COUNT -> no state change, counters unaffected.
  - SymValid in WAIT_GUESS -> SymIndex stays 16.
  - GuessValid in the same cycle as RoundDone -> ignored; a second GuessValid is judged.
- Reset mid-round:
  - Assert Rst_n=0 after 7 symbols -> next cycle IDLE, SymIndex=0, MatchCount=0, no RoundDone.
  - A new Start then counts from 0.
- Boundaries:
  - All 16 symbols match -> MatchCount=16 with no wrap.
  - ROUND_LEN=1 -> RoundDone after the first SymValid.
  - Start in RESULT -> new round with Correct cleared to 0.
